// File: rtl/uart_tx_unit_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM states,
// baud divisor helper and the idle line level.
package minisys_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL = 1'b1;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_unit_if.sv
// MMIO-side bundle of the UART transmitter: write strobe, status and pin.
// master = register block driving writes, slave = uart_tx_unit.
interface uart_tx_unit_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          tx_en;
    logic [7:0]    tx_data;
    logic          ovf_clr;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tx_busy;
    logic          overflow;
    logic          tx_done_int;
    logic          uart_tx;

    modport master (
        output tx_en, tx_data, ovf_clr,
        input  fifo_count, fifo_full, fifo_empty, tx_busy, overflow, tx_done_int, uart_tx
    );

    modport slave (
        input  tx_en, tx_data, ovf_clr,
        output fifo_count, fifo_full, fifo_empty, tx_busy, overflow, tx_done_int, uart_tx
    );
endinterface

// File: rtl/uart_tx_unit_baud_gen.sv
// Bit timer: counts 0..DIV-1 and ticks on the last count of each bit.
// restart_i pins the count at 0 so the first bit after it is a full DIV.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    output logic bit_tick_o
);
    localparam int BW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [BW-1:0] cnt_q, cnt_d;

    assign bit_tick_o = !restart_i && (cnt_q == BW'(DIV - 1));

    // Next count: hold at zero on restart, wrap after the last clock of a bit.
    always_comb begin
        cnt_d = cnt_q + BW'(1);
        if (restart_i || bit_tick_o)
            cnt_d = '0;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx_unit.sv
// Buffered UART transmitter: byte FIFO fed by MMIO writes, serialised
// 8N1 LSB first. Define UART_TX_PARITY_EN for 8E1 (even parity bit).
module uart_tx_unit
    import minisys_uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rst,
    uart_tx_unit_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, push, pop;

    // FSM / datapath
    uart_state_e   state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          line_d, uart_tx_q;
    logic          done_set, done_pend_q, tx_done_q;
    logic          ovf_q, ovf_set;
    logic          bit_tick;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // A full FIFO still accepts a write when the FSM pops on the same edge.
    assign push    = bus.tx_en && (!full || pop);
    assign ovf_set = bus.tx_en && full && !pop;

    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk        (clk),
        .rst        (rst),
        .restart_i  (state_q == IDLE),
        .bit_tick_o (bit_tick)
    );

    // Occupancy update from push/pop.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; contents need no reset, pointers/count guard validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= bus.tx_data;
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Next state, pop request and line level for the current bit.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        done_set  = 1'b0;
        line_d    = UART_IDLE_LVL;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_q];
                    state_d = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (bit_tick) begin
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                line_d = shreg_q[bit_idx_q];
                if (bit_tick) begin
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_d = ^shreg_q;
                if (bit_tick) state_d = STOP;
            end
`endif
            STOP: begin
                line_d = 1'b1;
                if (bit_tick) begin
                    // Chain straight into the next frame when more bytes wait.
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_q];
                        state_d = START;
                    end else begin
                        done_set = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM registers; pin and interrupt lag the state by one clock so the
    // pin is glitch-free and the interrupt lines up with the end of stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            uart_tx_q   <= UART_IDLE_LVL;
            done_pend_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            uart_tx_q   <= line_d;
            done_pend_q <= done_set;
            tx_done_q   <= done_pend_q;
        end
    end

    // Sticky overflow; a new drop outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)              ovf_q <= 1'b0;
        else if (ovf_set)     ovf_q <= 1'b1;
        else if (bus.ovf_clr) ovf_q <= 1'b0;
    end

    assign bus.fifo_count  = count_q;
    assign bus.fifo_full   = full;
    assign bus.fifo_empty  = empty;
    assign bus.tx_busy     = (state_q != IDLE);
    assign bus.overflow    = ovf_q;
    assign bus.tx_done_int = tx_done_q;
    assign bus.uart_tx     = uart_tx_q;
endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed bench for uart_tx_unit at DIV=10, FIFO_DEPTH=16.
// Expected pin levels come from a frame model over a queue of bytes.
module tb_uart_tx_unit;
    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int FR = 11 * DIV;
`else
    localparam int FR = 10 * DIV;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_unit_if #(.FIFO_DEPTH(16)) bus ();

    uart_tx_unit #(.CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pin level t clocks after the edge that wrote the first byte, with
    // every byte in exp_q sent back to back.
    function automatic logic exp_lvl(input int t);
        int f, p, k;
        logic [7:0] b;
        if (t < 2) return 1'b1;
        f = (t - 2) / FR;
        if (f >= exp_q.size()) return 1'b1;
        p = (t - 2) % FR;
        k = p / DIV;
        b = exp_q[f];
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.tx_en = 1'b0;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One byte into an idle unit; check pin, busy window and interrupt.
    task automatic run_single(input logic [7:0] b);
        exp_q.delete();
        exp_q.push_back(b);
        for (int t = 0; t <= FR + 5; t++) begin
            bus.tx_en   = (t == 0);
            bus.tx_data = b;
            tick();
            chk($sformatf("s%0h line t=%0d", b, t), bus.uart_tx, exp_lvl(t));
            chk($sformatf("s%0h busy t=%0d", b, t), bus.tx_busy, (t >= 1 && t <= FR));
            chk($sformatf("s%0h done t=%0d", b, t), bus.tx_done_int, (t == FR + 2));
            if (t == 0) chk("s count t0", bus.fifo_count, 1);
            if (t == 1) chk("s empty t1", bus.fifo_empty, 1);
        end
    endtask

    initial begin
        bus.tx_en   = 1'b0;
        bus.tx_data = 8'h00;
        bus.ovf_clr = 1'b0;
        tick();
        tick();
        chk("rst uart_tx", bus.uart_tx, 1);
        chk("rst busy",    bus.tx_busy, 0);
        chk("rst empty",   bus.fifo_empty, 1);
        chk("rst full",    bus.fifo_full, 0);
        chk("rst count",   bus.fifo_count, 0);
        chk("rst ovf",     bus.overflow, 0);
        chk("rst done",    bus.tx_done_int, 0);
        rst = 1'b0;

        // Single frames: 0x55 pattern and 0x07 (parity bit 1 when enabled).
        run_single(8'h55);
        run_single(8'h07);

        // Burst of 17 writes. 0x00 is popped on the edge after its write while
        // 0x01 lands, so 0x01..0x10 exactly fill the 16 entries; the next two
        // writes are the drops. 0xA5 arrives on the end-of-stop pop edge.
        do_reset();
        exp_q.delete();
        for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'hA5);
        for (int t = 0; t <= 18 * FR + 5; t++) begin
            bus.tx_en   = 1'b0;
            bus.ovf_clr = 1'b0;
            if (t <= 16)      begin bus.tx_en = 1'b1; bus.tx_data = 8'(t); end
            else if (t == 17) begin bus.tx_en = 1'b1; bus.tx_data = 8'h11; end
            else if (t == 18) begin bus.tx_en = 1'b1; bus.tx_data = 8'h12; bus.ovf_clr = 1'b1; end
            else if (t == 19) bus.ovf_clr = 1'b1;
            else if (t == FR + 1) begin bus.tx_en = 1'b1; bus.tx_data = 8'hA5; end
            tick();
            chk($sformatf("b line t=%0d", t), bus.uart_tx, exp_lvl(t));
            chk($sformatf("b busy t=%0d", t), bus.tx_busy, (t >= 1 && t <= 18 * FR));
            chk($sformatf("b done t=%0d", t), bus.tx_done_int, (t == 18 * FR + 2));
            if (t == 16) begin
                chk("b count full", bus.fifo_count, 16);
                chk("b full flag",  bus.fifo_full, 1);
                chk("b ovf none",   bus.overflow, 0);
            end
            if (t == 17) begin
                chk("b ovf drop",   bus.overflow, 1);
                chk("b count drop", bus.fifo_count, 16);
            end
            if (t == 18) chk("b ovf set>clr", bus.overflow, 1);
            if (t == 19) chk("b ovf clr",     bus.overflow, 0);
            if (t == FR + 1) begin
                chk("b popwr count", bus.fifo_count, 16);
                chk("b popwr ovf",   bus.overflow, 0);
            end
        end

        // Reset during data bit 4 of 0x3C with three bytes queued.
        do_reset();
        exp_q.delete();
        exp_q.push_back(8'h3C);
        for (int t = 0; t <= 300; t++) begin
            bus.tx_en = (t <= 3);
            case (t)
                0: bus.tx_data = 8'h3C;
                1: bus.tx_data = 8'h11;
                2: bus.tx_data = 8'h22;
                default: bus.tx_data = 8'h33;
            endcase
            rst = (t == 55);
            tick();
            if (t == 3) chk("r count3", bus.fifo_count, 3);
            if (t < 55) chk($sformatf("r line t=%0d", t), bus.uart_tx, exp_lvl(t));
            if (t == 55) begin
                chk("r count0", bus.fifo_count, 0);
                chk("r busy0",  bus.tx_busy, 0);
                chk("r empty",  bus.fifo_empty, 1);
            end
            if (t >= 55) begin
                chk($sformatf("r idle t=%0d", t), bus.uart_tx, 1);
                chk($sformatf("r nodone t=%0d", t), bus.tx_done_int, 0);
            end
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
